// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI event recorder: status nibbles, record FSM
// states and the {note_on, note, delay} record packing used by the players.
package midi_pkg;

    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [7:0] RT_FIRST = 8'hF8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REC   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } rec_state_t;

    // Records are packed MSB-first as {note_on, note, delay}; callers truncate to their width.
    function automatic logic [31:0] pack_record(input logic on, input logic [31:0] note,
                                                input logic [31:0] delay,
                                                input int note_bits, input int delay_bits);
        return ({31'd0, on} << (note_bits + delay_bits)) | (note << delay_bits) | delay;
    endfunction

    function automatic logic unpack_on(input logic [31:0] rec, input int note_bits,
                                       input int delay_bits);
        return rec[note_bits + delay_bits];
    endfunction

    function automatic logic [31:0] unpack_note(input logic [31:0] rec, input int note_bits,
                                                input int delay_bits);
        return (rec >> delay_bits) & ((32'd1 << note_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] unpack_delay(input logic [31:0] rec, input int delay_bits);
        return rec & ((32'd1 << delay_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Single-channel MIDI note message parser with running status. Emits a
// combinational one-cycle event on the byte that completes a note message.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int CHANNEL   = 0,
    parameter int NOTE_MIN  = 0,
    parameter int NOTE_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 ev_valid,
    output logic                 ev_on,
    output logic [NOTE_BITS-1:0] ev_note
);

    localparam logic [3:0] CHAN_NIB = 4'(CHANNEL);

    logic       run_valid_r, run_valid_s;
    logic       run_on_r, run_on_s;
    logic       have_note_r, have_note_s;
    logic [6:0] note_r, note_s;
    logic [31:0] note_ext_s;
    logic       note_in_range_s;

    assign note_ext_s      = {25'd0, note_r};
    assign note_in_range_s = (note_ext_s >= 32'(NOTE_MIN)) &&
                             ((note_ext_s - 32'(NOTE_MIN)) < (32'd1 << NOTE_BITS));
    assign ev_note         = NOTE_BITS'(note_ext_s - 32'(NOTE_MIN));

    // Byte classification; realtime bytes leave a half-received message intact.
    always_comb begin
        run_valid_s = run_valid_r;
        run_on_s    = run_on_r;
        have_note_s = have_note_r;
        note_s      = note_r;
        ev_valid    = 1'b0;
        ev_on       = 1'b0;
        if (rx_valid) begin
            if (!rx_data[7]) begin
                if (run_valid_r && !have_note_r) begin
                    note_s      = rx_data[6:0];
                    have_note_s = 1'b1;
                end else if (run_valid_r) begin
                    have_note_s = 1'b0;
                    ev_valid    = note_in_range_s;
                    ev_on       = run_on_r && (rx_data[6:0] != 7'd0);
                end else begin
                    have_note_s = 1'b0;
                end
            end else if (rx_data >= RT_FIRST) begin
                run_valid_s = run_valid_r;
            end else if (((rx_data[7:4] == NOTE_ON) || (rx_data[7:4] == NOTE_OFF)) &&
                         (rx_data[3:0] == CHAN_NIB)) begin
                run_valid_s = 1'b1;
                run_on_s    = (rx_data[7:4] == NOTE_ON);
                have_note_s = 1'b0;
            end else begin
                run_valid_s = 1'b0;
                have_note_s = 1'b0;
            end
        end else begin
            ev_valid = 1'b0;
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_valid_r <= 1'b0;
            run_on_r    <= 1'b0;
            have_note_r <= 1'b0;
            note_r      <= 7'd0;
        end else begin
            run_valid_r <= run_valid_s;
            run_on_r    <= run_on_s;
            have_note_r <= have_note_s;
            note_r      <= note_s;
        end
    end

endmodule

// File: rtl/midi_event_recorder.sv
// Records a monophonic MIDI channel as {note_on, note, delay} records timed by
// the tempo tick, in the same format the channel players replay from ROM.
module midi_event_recorder
    import midi_pkg::*;
#(
    parameter int CHANNEL    = 0,
    parameter int NOTE_MIN   = 0,
    parameter int NOTE_BITS  = 7,
    parameter int DELAY_BITS = 12,
    parameter int ADDR_BITS  = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    input  logic                            tick,
    input  logic                            arm,
    input  logic                            stop,
    output logic                            wr_en,
    output logic [ADDR_BITS-1:0]            wr_addr,
    output logic [NOTE_BITS+DELAY_BITS:0]   wr_data,
    output logic [ADDR_BITS-1:0]            msg_len,
    output logic                            recording,
    output logic                            full,
    output logic                            done
);

    localparam int REC_BITS = 1 + NOTE_BITS + DELAY_BITS;
    localparam logic [DELAY_BITS-1:0] DELAY_MAX = '1;
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR = '1;

    rec_state_t             state_r, state_s;
    logic                   cur_on_r, cur_on_s;
    logic [NOTE_BITS-1:0]   cur_note_r, cur_note_s;
    logic [DELAY_BITS-1:0]  cnt_r, cnt_s;

    logic                   wr_en_s, recording_s, full_s, done_s;
    logic [ADDR_BITS-1:0]   wr_addr_s, msg_len_s;
    logic [REC_BITS-1:0]    wr_data_s;

    logic                   ev_valid_s, ev_on_s;
    logic [NOTE_BITS-1:0]   ev_note_s;
    logic                   close_s, write_s, cnt_max_s;
    logic [DELAY_BITS-1:0]  rec_delay_s;

    midi_msg_parser #(
        .CHANNEL  (CHANNEL),
        .NOTE_MIN (NOTE_MIN),
        .NOTE_BITS(NOTE_BITS)
    ) u_parser (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ev_valid (ev_valid_s),
        .ev_on    (ev_on_s),
        .ev_note  (ev_note_s)
    );

    // Record FSM, tick counter and write-port decisions. The address bumps the
    // cycle after each write, so wr_addr_s is the address a write issued now carries.
    // After the write to the last address, wr_addr/msg_len wrap and full marks DEPTH records.
    always_comb begin
        state_s     = state_r;
        wr_addr_s   = wr_en ? (wr_addr + ADDR_BITS'(1)) : wr_addr;
        msg_len_s   = wr_en ? (msg_len + ADDR_BITS'(1)) : msg_len;
        full_s      = full;
        done_s      = done;
        cur_on_s    = cur_on_r;
        cur_note_s  = cur_note_r;
        cnt_s       = cnt_r;
        write_s     = 1'b0;
        rec_delay_s = cnt_r;
        cnt_max_s   = (cnt_r == DELAY_MAX);
        close_s     = ev_valid_s && (ev_on_s || (cur_on_r && (cur_note_r == ev_note_s)));
        case (state_r)
            IDLE, DONE: begin
                if (arm) begin
                    state_s    = REC;
                    wr_addr_s  = '0;
                    msg_len_s  = '0;
                    full_s     = 1'b0;
                    done_s     = 1'b0;
                    cur_on_s   = 1'b0;
                    cur_note_s = '0;
                    cnt_s      = '0;
                end else begin
                    state_s = state_r;
                end
            end
            REC: begin
                if (close_s) begin
                    write_s = 1'b1;
                    if (tick) begin
                        rec_delay_s = cnt_max_s ? DELAY_MAX : (cnt_r + DELAY_BITS'(1));
                        cnt_s       = cnt_max_s ? DELAY_BITS'(1) : '0;
                    end else begin
                        rec_delay_s = cnt_r;
                        cnt_s       = '0;
                    end
                    cur_on_s   = ev_on_s;
                    cur_note_s = ev_note_s;
                end else if (tick) begin
                    if (cnt_max_s) begin
                        write_s     = 1'b1;
                        rec_delay_s = DELAY_MAX;
                        cnt_s       = DELAY_BITS'(1);
                    end else begin
                        cnt_s = cnt_r + DELAY_BITS'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
                if (write_s && (wr_addr_s == LAST_ADDR)) begin
                    state_s = DONE;
                    full_s  = 1'b1;
                    done_s  = 1'b1;
                end else if (stop) begin
                    state_s = FLUSH;
                end else begin
                    state_s = REC;
                end
            end
            FLUSH: begin
                write_s     = 1'b1;
                rec_delay_s = cnt_r;
                state_s     = DONE;
                done_s      = 1'b1;
                full_s      = (wr_addr_s == LAST_ADDR);
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        wr_en_s     = write_s;
        wr_data_s   = write_s ? REC_BITS'(pack_record(cur_on_r, 32'(cur_note_r),
                                                      32'(rec_delay_s), NOTE_BITS, DELAY_BITS))
                              : wr_data;
        recording_s = (state_s == REC);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cur_on_r   <= 1'b0;
            cur_note_r <= '0;
            cnt_r      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            msg_len    <= '0;
            recording  <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            cur_on_r   <= cur_on_s;
            cur_note_r <= cur_note_s;
            cnt_r      <= cnt_s;
            wr_en      <= wr_en_s;
            wr_addr    <= wr_addr_s;
            wr_data    <= wr_data_s;
            msg_len    <= msg_len_s;
            recording  <= recording_s;
            full       <= full_s;
            done       <= done_s;
        end
    end

endmodule
